// File: rtl/sqrt_core.sv
// sqrt_core: iterative restoring integer square root.
// Produces result = floor(sqrt(A)) one root bit per clock, IN_WIDTH/2 steps
// after the init-sampling edge, and holds it in DONE until the next init.
// Optional feature macro: SQRT_REM_EN -- when defined, rem carries
// A - result*result; when undefined, rem is tied to 0 and no remainder
// output register is built. The port list is identical either way.
module sqrt_core #(
  parameter int IN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [IN_WIDTH-1:0]   A,
  output logic [IN_WIDTH/2-1:0] result,
  output logic [IN_WIDTH/2:0]   rem,
  output logic                  busy,
  output logic                  done
);

  localparam int RW   = IN_WIDTH / 2;   // root width
  localparam int REMW = RW + 2;         // working remainder width, never overflows
  localparam int CW   = $clog2(RW + 1); // counter must hold RW itself

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_shift;
  logic [RW-1:0]       r_root;
  logic [REMW-1:0]     r_rmd;
  logic [CW-1:0]       r_cnt;
  logic [RW-1:0]       r_result;
  logic                r_busy;
  logic                r_done;

  logic [REMW-1:0]     w_rp;
  logic [REMW-1:0]     w_t;
  logic                w_ge;
  logic [REMW-1:0]     w_rmd_nxt;
  logic [RW-1:0]       w_root_nxt;
  logic                w_last;

  // One restoring digit step: bring down two radicand bits, trial-subtract 4*root+1.
  always_comb begin
    w_rp       = {r_rmd[REMW-3:0], r_shift[IN_WIDTH-1 -: 2]};
    w_t        = {r_root, 2'b01};
    w_ge       = (w_rp >= w_t);
    w_rmd_nxt  = w_ge ? (w_rp - w_t) : w_rp;
    w_root_nxt = {r_root[RW-2:0], w_ge};
    w_last     = (r_cnt == CW'(1));
  end

  // Control FSM plus datapath registers; outputs registered, only updated on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_root   <= '0;
      r_rmd    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (init) begin
            r_shift <= A;
            r_root  <= '0;
            r_rmd   <= '0;
            r_cnt   <= CW'(RW);
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // init is deliberately not looked at here: a running job always finishes
          r_rmd   <= w_rmd_nxt;
          r_root  <= w_root_nxt;
          r_shift <= {r_shift[IN_WIDTH-3:0], 2'b00};
          r_cnt   <= r_cnt - CW'(1);
          if (w_last) begin
            r_result <= w_root_nxt;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SQRT_REM_EN
  logic [RW:0] r_rem;

  // Remainder output register: captured on the same edge as the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rem <= '0;
    else if (r_state == S_CALC && w_last)
      r_rem <= w_rmd_nxt[RW:0];
  end

  assign rem = r_rem;
`else
  assign rem = '0;
`endif

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: doc/sqrt_core.md
SQRT_CORE -- requirements
Module: sqrt_core

Interface
REQ-001 SHALL have parameter: IN_WIDTH, default 16, radicand width (even, >= 4); all widths below are given for the default.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: init  input  1  start request, sampled on rising clk.
REQ-005 SHALL have port: A  input  16  unsigned radicand.
REQ-006 SHALL have port: result  output  8  floor(sqrt(A)).
REQ-007 SHALL have port: rem  output  9  A - result*result.
REQ-008 SHALL have port: busy  output  1  high while iterating.
REQ-009 SHALL have port: done  output  1  high while result/rem are valid.
REQ-010 SHALL be the compute core that the peripheral_sqrt wrapper drives: init from the wrapper's init register, A from its operand register, result/done read back by the wrapper.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 In IDLE or DONE with init=1 at a rising edge: SHALL capture A into an internal shift register, clear the root and remainder registers, load iteration counter with IN_WIDTH/2, clear done, set busy, and go to CALC.
REQ-013 In CALC, each edge SHALL process one restoring digit step: r' = (r<<2) | top two bits of shift register; shift register <<= 2; t = (root<<2)|1; if r' >= t then r = r'-t and root = (root<<1)|1, else r = r' and root = root<<1; counter decrements.
REQ-014 Internal remainder register SHALL be 10 bits (IN_WIDTH/2+2) so that no intermediate overflows.
REQ-015 When the counter reaches 0 on a CALC edge, the FSM SHALL go to DONE at that edge: busy=0, done=1, result=root, rem per REQ-027/028. Result is valid exactly 8 edges after the init-sampling edge.
REQ-016 done SHALL stay high in DONE until init is sampled again or reset occurs; no automatic return to IDLE.
REQ-017 init asserted while in CALC SHALL be ignored; the running computation completes unaffected.
REQ-018 Changes on A after the init-sampling edge SHALL NOT affect the running computation.
REQ-019 result and rem SHALL hold their last values outside DONE until the next completion; they SHALL NOT show intermediate iteration values.
REQ-020 init held high continuously SHALL cause back-to-back computations: one result per 9 edges, with done high for exactly one cycle between runs.
REQ-021 Boundary values: A=0 gives result 0, rem 0; A=0xFFFF gives result 0xFF, rem 0x1FE.

Reset
REQ-022 reset=1 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, result=0, rem=0, and clear the counter, root, remainder and shift registers.
REQ-023 reset asserted mid-CALC SHALL abort the computation; no done pulse follows after release.
REQ-024 After reset release, the first init sampled SHALL start a fresh computation per REQ-012.

Configuration
REQ-025 Macro SQRT_REM_EN SHALL select the remainder feature.
REQ-026 The port list SHALL be identical with and without SQRT_REM_EN.
REQ-027 With SQRT_REM_EN defined: rem SHALL carry the final remainder in DONE.
REQ-028 Without SQRT_REM_EN: rem SHALL be constant 0 and the remainder output register SHALL NOT be implemented; result and timing SHALL be unchanged.

Verification
REQ-029 Scenario: A=0x0441, init pulsed 1 cycle -> busy high for 8 cycles, then done=1, result=0x21, rem=0.
REQ-030 Scenario: A=0xFFFF -> result=0xFF, rem=0x1FE (or 0 without SQRT_REM_EN); then A=0x0000 -> result=0, rem=0.
REQ-031 Scenario: A=0x0002 -> result=0x01, rem=0x001; A changed to 0x0441 during CALC -> result still 0x01.
REQ-032 Scenario: init re-pulsed in the 4th CALC cycle of A=0x0064 -> ignored; done exactly 8 edges after the first init, result=0x0A.
REQ-033 Scenario: reset asserted mid-CALC (asynchronously, between edges) -> busy=0, done=0 and result=0 immediately; no done afterwards until a new init.
REQ-034 Scenario: exhaustive sweep of A=0..0xFFFF against a reference model -> result*result <= A < (result+1)^2 and rem=A-result^2 for every value.
